// File: rtl/uart_rx_fr.sv
// uart_rx_fr: parametrised mid-bit sampling UART receiver with glitch
// rejection, parity/framing/overrun flags and a held-word read handshake.
module uart_rx_fr #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 rx,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int NW   = $clog2(DATA_BITS + 1);
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] LAST_D  = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] LAST_S  = NW'(STOP_BITS - 1);
    localparam logic          ODD     = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_n;
    logic                 rx_q, rxs;
    logic [CW-1:0]        bctr, bctr_n;
    logic [NW-1:0]        nbit, nbit_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic                 perr, perr_n;
    logic                 ferr, ferr_n;
    logic                 armed, armed_n;
    logic                 commit;
    logic                 tick_half, tick_full;

    assign tick_half = (bctr == HALF_M1);
    assign tick_full = (bctr == FULL_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q <= 1'b1;
            rxs  <= 1'b1;
        end else begin
            rx_q <= rx;
            rxs  <= rx_q;
        end
    end

    always_comb begin
        state_n = state;
        bctr_n  = bctr + 1'b1;
        nbit_n  = nbit;
        sh_n    = sh;
        perr_n  = perr;
        ferr_n  = ferr;
        armed_n = armed;
        commit  = 1'b0;
        unique case (state)
            S_IDLE: begin
                bctr_n = '0;
                nbit_n = '0;
                perr_n = 1'b0;
                ferr_n = 1'b0;
                if (rxs)
                    armed_n = 1'b1;
                if (en && armed && !rxs)
                    state_n = S_START;
            end
            S_START: begin
                if (tick_half) begin
                    bctr_n  = '0;
                    state_n = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick_full) begin
                    bctr_n = '0;
                    sh_n   = {rxs, sh[DATA_BITS-1:1]};
                    nbit_n = nbit + 1'b1;
                    if (nbit == LAST_D) begin
                        nbit_n  = '0;
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (tick_full) begin
                    bctr_n  = '0;
                    perr_n  = ((^sh) ^ rxs) != ODD;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (tick_full) begin
                    bctr_n = '0;
                    nbit_n = nbit + 1'b1;
                    if (!rxs)
                        ferr_n = 1'b1;
                    if (nbit == LAST_S) begin
                        commit  = 1'b1;
                        state_n = S_IDLE;
                        // a low stop bit may be a break: wait for idle high
                        if (ferr_n)
                            armed_n = 1'b0;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (state != S_IDLE && !en) begin
            state_n = S_IDLE;
            bctr_n  = '0;
            armed_n = armed;
            commit  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            bctr  <= '0;
            nbit  <= '0;
            sh    <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            armed <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            bctr  <= bctr_n;
            nbit  <= nbit_n;
            sh    <= sh_n;
            perr  <= perr_n;
            ferr  <= ferr_n;
            armed <= armed_n;
            busy  <= (state_n != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (commit && valid && !rd) begin
            overrun <= 1'b1;
        end else if (commit) begin
            dout       <= sh;
            parity_err <= perr;
            frame_err  <= ferr_n;
            valid      <= 1'b1;
            if (rd)
                overrun <= 1'b0;
        end else if (rd && valid) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_fr.sv
// tb_uart_rx_fr: table-driven frames with a scoreboard over three
// receiver configurations (8N1, 8E1, 9N2) plus hand-written corner cases.
module tb_uart_rx_fr;
    logic       clk;
    logic       rst;
    logic [2:0] en_v, rx_v, rd_v;
    logic [2:0] valid_v, perr_v, ferr_v, ovr_v, busy_v;
    logic [7:0] dout0, dout1;
    logic [8:0] dout2;

    uart_rx_fr #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .en(en_v[0]), .rx(rx_v[0]), .rd(rd_v[0]),
        .dout(dout0), .valid(valid_v[0]), .parity_err(perr_v[0]),
        .frame_err(ferr_v[0]), .overrun(ovr_v[0]), .busy(busy_v[0])
    );
    uart_rx_fr #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .en(en_v[1]), .rx(rx_v[1]), .rd(rd_v[1]),
        .dout(dout1), .valid(valid_v[1]), .parity_err(perr_v[1]),
        .frame_err(ferr_v[1]), .overrun(ovr_v[1]), .busy(busy_v[1])
    );
    uart_rx_fr #(.CLKS_PER_BIT(16), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .en(en_v[2]), .rx(rx_v[2]), .rd(rd_v[2]),
        .dout(dout2), .valid(valid_v[2]), .parity_err(perr_v[2]),
        .frame_err(ferr_v[2]), .overrun(ovr_v[2]), .busy(busy_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic [8:0] data;
        logic       pbit;
        logic       s1;
        logic       s2;
        logic       eperr;
        logic       eferr;
    } vec_t;

    typedef struct {
        logic [8:0] dout;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t sbq[$];
    vec_t vt[13];
    int   errors = 0;
    int   checks = 0;
    int   n;
    logic seen;

    function automatic logic [8:0] dout_of(input int ch);
        case (ch)
            0:       return {1'b0, dout0};
            1:       return {1'b0, dout1};
            default: return dout2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bit_t(input int ch, input logic b);
        rx_v[ch] = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send(input int ch, input logic [8:0] d, input logic pb,
                        input logic s1, input logic s2);
        int nb;
        nb = (ch == 2) ? 9 : 8;
        bit_t(ch, 1'b0);
        for (int i = 0; i < nb; i++)
            bit_t(ch, d[i]);
        if (ch == 1)
            bit_t(ch, pb);
        bit_t(ch, s1);
        if (ch == 2)
            bit_t(ch, s2);
        rx_v[ch] = 1'b1;
    endtask

    task automatic read_check(input int ch);
        exp_t e;
        int   w;
        w = 0;
        while (!valid_v[ch] && w < 600) begin
            @(negedge clk);
            w++;
        end
        chk("valid_wait", valid_v[ch], 9'd1);
        chk("sb_nonempty", sbq.size() > 0, 9'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("dout", dout_of(ch), e.dout);
            chk("parity_err", perr_v[ch], e.perr);
            chk("frame_err", ferr_v[ch], e.ferr);
        end
        rd_v[ch] = 1'b1;
        @(negedge clk);
        rd_v[ch] = 1'b0;
        chk("valid_after_rd", valid_v[ch], 9'd0);
    endtask

    initial begin
        vt[0]  = '{0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{0, 9'h0FF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{0, 9'h055, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{0, 9'h080, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{1, 9'h03C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{1, 9'h03C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[6]  = '{1, 9'h001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{1, 9'h007, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[8]  = '{1, 9'h03C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[9]  = '{2, 9'h1FF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[10] = '{2, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[11] = '{2, 9'h155, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[12] = '{2, 9'h0AA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        rst  = 1'b1;
        en_v = 3'b111;
        rd_v = 3'b000;
        rx_v = 3'b111;
        repeat (3) @(negedge clk);
        chk("rst_dout", dout_of(0), 9'h000);
        chk("rst_valid", valid_v[0], 9'd0);
        chk("rst_perr", perr_v[1], 9'd0);
        chk("rst_ferr", ferr_v[0], 9'd0);
        chk("rst_ovr", ovr_v[0], 9'd0);
        chk("rst_busy", busy_v, 9'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // latency from rx falling edge to valid
        sbq.push_back('{9'h0A5, 1'b0, 1'b0});
        n = 0;
        fork
            send(0, 9'h0A5, 1'b0, 1'b1, 1'b1);
            begin
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!valid_v[0] && n < 400);
            end
        join
        checks++;
        if (n < 154 || n > 156) begin
            errors++;
            $display("FAIL valid_latency: got %0d cycles expected 155 +-1", n);
        end
        read_check(0);

        for (int i = 0; i < 13; i++) begin
            sbq.push_back('{vt[i].data, vt[i].eperr, vt[i].eferr});
            send(vt[i].ch, vt[i].data, vt[i].pbit, vt[i].s1, vt[i].s2);
            read_check(vt[i].ch);
            repeat (8) @(negedge clk);
        end

        // start-bit glitch
        rx_v[0] = 1'b0;
        repeat (5) @(negedge clk);
        rx_v[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (busy_v[0]) seen = 1'b1;
        end
        chk("glitch_busy_seen", seen, 9'd1);
        repeat (32) @(negedge clk);
        chk("glitch_busy", busy_v[0], 9'd0);
        chk("glitch_valid", valid_v[0], 9'd0);

        // break: low stop bit, then line held low for 40 bit times
        sbq.push_back('{9'h000, 1'b0, 1'b1});
        send(0, 9'h000, 1'b0, 1'b0, 1'b0);
        rx_v[0] = 1'b0;
        repeat (8) @(negedge clk);
        read_check(0);
        seen = 1'b0;
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            if (busy_v[0] || valid_v[0]) seen = 1'b1;
        end
        chk("break_no_retrigger", seen, 9'd0);
        rx_v[0] = 1'b1;
        repeat (48) @(negedge clk);
        chk("break_release_valid", valid_v[0], 9'd0);
        chk("break_release_busy", busy_v[0], 9'd0);

        // overrun without read
        send(0, 9'h011, 1'b0, 1'b1, 1'b1);
        send(0, 9'h022, 1'b0, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        chk("ovr_dout", dout_of(0), 9'h011);
        chk("ovr_flag", ovr_v[0], 9'd1);
        chk("ovr_valid", valid_v[0], 9'd1);
        rd_v[0] = 1'b1;
        @(negedge clk);
        rd_v[0] = 1'b0;
        chk("ovr_clr", ovr_v[0], 9'd0);
        chk("ovr_rd_valid", valid_v[0], 9'd0);
        repeat (8) @(negedge clk);

        // read strobe lands on the second frame's commit cycle
        fork
            begin
                send(0, 9'h011, 1'b0, 1'b1, 1'b1);
                send(0, 9'h022, 1'b0, 1'b1, 1'b1);
            end
            begin
                repeat (314) @(negedge clk);
                rd_v[0] = 1'b1;
                @(negedge clk);
                rd_v[0] = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        chk("rdc_dout", dout_of(0), 9'h022);
        chk("rdc_ovr", ovr_v[0], 9'd0);
        chk("rdc_valid", valid_v[0], 9'd1);
        sbq.push_back('{9'h022, 1'b0, 1'b0});
        read_check(0);

        // enable dropped mid-DATA
        fork
            send(0, 9'h077, 1'b0, 1'b1, 1'b1);
            begin
                repeat (60) @(negedge clk);
                chk("abort_busy_before", busy_v[0], 9'd1);
                en_v[0] = 1'b0;
                @(negedge clk);
                chk("abort_idle", busy_v[0], 9'd0);
            end
        join
        en_v[0] = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_commit", valid_v[0], 9'd0);
        sbq.push_back('{9'h05A, 1'b0, 1'b0});
        send(0, 9'h05A, 1'b0, 1'b1, 1'b1);
        read_check(0);

        // reset mid-frame with a word held
        send(0, 9'h0F0, 1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("pre_rst_valid", valid_v[0], 9'd1);
        fork
            send(0, 9'h0C3, 1'b0, 1'b1, 1'b1);
            begin
                repeat (80) @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                chk("mrst_dout", dout_of(0), 9'h000);
                chk("mrst_valid", valid_v[0], 9'd0);
                chk("mrst_perr", perr_v[0], 9'd0);
                chk("mrst_ferr", ferr_v[0], 9'd0);
                chk("mrst_ovr", ovr_v[0], 9'd0);
                chk("mrst_busy", busy_v[0], 9'd0);
            end
        join
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_valid", valid_v[0], 9'd0);
        chk("sb_drained", sbq.size(), 9'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
